// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus between pc_fetch_unit (master) and instruction memory (slave).
interface pc_fetch_unit_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC and single-outstanding instruction fetch stage feeding decode; BOOT/FETCH/ISSUE/HALTED FSM.
// Optional retired-instruction counter output enabled by defining PC_FETCH_INSTRET_EN.
module pc_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_fetch_unit_if.master  imem,
  output logic [XLEN-1:0]  instr,
  output logic             instr_valid,
  output logic [XLEN-1:0]  pc,
  input  logic             pc_src,
  input  logic [XLEN-1:0]  imm_ext,
  input  logic             halt,
  input  logic             stall,
  output logic             halted,
  output logic             misaligned
`ifdef PC_FETCH_INSTRET_EN
  ,
  output logic [XLEN-1:0]  instret
`endif
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    ISSUE,
    HALTED
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] next_pc;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;
  logic            mis_q, mis_d;
`ifdef PC_FETCH_INSTRET_EN
  logic [XLEN-1:0] instret_q, instret_d;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    halted_d = halted_q;
    mis_d    = mis_q;
`ifdef PC_FETCH_INSTRET_EN
    instret_d = instret_q;
`endif
    next_pc = pc_src ? (pc_q + imm_ext) : (pc_q + XLEN'(4));

    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // stall > halt > misalign > normal update
        if (!stall) begin
          if (halt) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end else begin
`ifdef PC_FETCH_INSTRET_EN
            instret_d = instret_q + XLEN'(1);
`endif
            if (next_pc[1:0] != 2'b00) begin
              state_d  = HALTED;
              halted_d = 1'b1;
              mis_d    = 1'b1;
            end else begin
              pc_d    = next_pc;
              state_d = FETCH;
            end
          end
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = BOOT;
    endcase

    // Outputs registered from the next state so they are glitch-free Moore outputs.
    req_d   = (state_d == FETCH);
    valid_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
`ifdef PC_FETCH_INSTRET_EN
      instret_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      mis_q    <= mis_d;
`ifdef PC_FETCH_INSTRET_EN
      instret_q <= instret_d;
`endif
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign halted         = halted_q;
  assign misaligned     = mis_q;
`ifdef PC_FETCH_INSTRET_EN
  assign instret        = instret_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: per-instruction program tables expanded into a
// cycle schedule of expected outputs, checked every cycle, plus literal fetch-address pins.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic        pc_src;
  logic [31:0] imm_ext;
  logic        halt;
  logic        stall;
  logic        halted;
  logic        misaligned;
`ifdef PC_FETCH_INSTRET_EN
  logic [31:0] instret;
`endif

  pc_fetch_unit_if #(.XLEN(32)) bus ();

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_src      (pc_src),
    .imm_ext     (imm_ext),
    .halt        (halt),
    .stall       (stall),
    .halted      (halted),
    .misaligned  (misaligned)
`ifdef PC_FETCH_INSTRET_EN
    ,
    .instret     (instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One program entry: memory wait cycles, stall cycles, decode response, instruction word.
  typedef struct {
    int unsigned w;
    int unsigned s;
    logic        src;
    logic [31:0] imm;
    logic        hlt;
    logic [31:0] word;
  } ent_t;

  // One cycle of the schedule: inputs to drive and outputs required.
  typedef struct {
    logic        ack, stall, src, hlt;
    logic [31:0] rdata, imm;
    logic        req, valid, h, m;
    logic [31:0] pc, instr, ret;
  } cyc_t;

  ent_t        prog[$];
  cyc_t        sch[512];
  int unsigned n_cyc;
  int unsigned cur_t;
  bit          running;
  logic [31:0] obs[$];
  int unsigned errors;
  int unsigned checks;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d, t=%0t)", nm, act, exp, cur_t, $time);
    end
  endtask

  // Expand the program table into a cycle-by-cycle schedule from the fetch/issue rules.
  task automatic build(input int unsigned tail);
    logic [31:0] mpc, minstr, mret, nxt;
    bit          mh, mm;
    int unsigned t;
    cyc_t        c;
    mpc = 32'h0; minstr = 32'h0; mret = 32'h0; mh = 0; mm = 0; t = 0;
    c = '{ack: 1'b1, stall: 1'b0, src: 1'b0, hlt: 1'b0, rdata: 32'hB007_0000, imm: 32'h0,
           req: 1'b0, valid: 1'b0, h: 1'b0, m: 1'b0, pc: mpc, instr: minstr, ret: mret};
    sch[t] = c; t++;
    foreach (prog[k]) begin
      if (mh) break;
      for (int unsigned j = 0; j <= prog[k].w; j++) begin
        c = '{ack: (j == prog[k].w), stall: 1'b0, src: 1'b0, hlt: 1'b0,
               rdata: (j == prog[k].w) ? prog[k].word : (32'hBAD0_0000 + t), imm: 32'h0,
               req: 1'b1, valid: 1'b0, h: mh, m: mm, pc: mpc, instr: minstr, ret: mret};
        sch[t] = c; t++;
      end
      minstr = prog[k].word;
      for (int unsigned j = 0; j <= prog[k].s; j++) begin
        c = '{ack: (j == 0), stall: (j < prog[k].s), src: prog[k].src, hlt: prog[k].hlt,
               rdata: 32'hACE0_0000 + t, imm: prog[k].imm,
               req: 1'b0, valid: 1'b1, h: mh, m: mm, pc: mpc, instr: minstr, ret: mret};
        sch[t] = c; t++;
      end
      if (prog[k].hlt) begin
        mh = 1;
      end else begin
        mret = mret + 1;
        nxt = prog[k].src ? (mpc + prog[k].imm) : (mpc + 32'd4);
        if (nxt[1:0] != 2'b00) begin
          mh = 1; mm = 1;
        end else begin
          mpc = nxt;
        end
      end
    end
    for (int unsigned j = 0; j < tail; j++) begin
      c = '{ack: 1'b1, stall: 1'b0, src: 1'b1, hlt: 1'b0, rdata: 32'hDEAD_0000 + t, imm: 32'h4,
             req: 1'b0, valid: 1'b0, h: mh, m: mm, pc: mpc, instr: minstr, ret: mret};
      sch[t] = c; t++;
    end
    n_cyc = t;
  endtask

  task automatic drive(input int unsigned t);
    bus.imem_ack   = sch[t].ack;
    bus.imem_rdata = sch[t].rdata;
    stall          = sch[t].stall;
    pc_src         = sch[t].src;
    imm_ext        = sch[t].imm;
    halt           = sch[t].hlt;
  endtask

  task automatic idle_inputs();
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
    stall = 1'b0; pc_src = 1'b0; imm_ext = 32'h0; halt = 1'b0;
  endtask

  // Reset, release just after a rising edge, then play the first `limit` schedule cycles.
  task automatic run(input int unsigned limit);
    idle_inputs();
    rst_n = 1'b0;
    obs.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int unsigned t = 0; t < limit; t++) begin
      cur_t = t;
      drive(t);
      running = 1'b1;
      @(posedge clk);
      #1;
    end
    running = 1'b0;
  endtask

  // Single compare process against the expanded schedule, sampled mid-cycle.
  always @(negedge clk) begin
    if (running) begin
      chk("imem_req", {31'h0, bus.imem_req}, {31'h0, sch[cur_t].req});
      if (sch[cur_t].req) chk("imem_addr", bus.imem_addr, sch[cur_t].pc);
      chk("instr_valid", {31'h0, instr_valid}, {31'h0, sch[cur_t].valid});
      chk("pc", pc, sch[cur_t].pc);
      chk("instr", instr, sch[cur_t].instr);
      chk("halted", {31'h0, halted}, {31'h0, sch[cur_t].h});
      chk("misaligned", {31'h0, misaligned}, {31'h0, sch[cur_t].m});
`ifdef PC_FETCH_INSTRET_EN
      chk("instret", instret, sch[cur_t].ret);
`endif
      if (bus.imem_req && bus.imem_ack) obs.push_back(bus.imem_addr);
    end
  end

  task automatic chk_fetches(input string nm, input logic [31:0] exp[$]);
    chk({nm, "_count"}, obs.size(), exp.size());
    foreach (exp[i]) begin
      if (i < obs.size()) chk({nm, "_addr"}, obs[i], exp[i]);
    end
  endtask

  initial begin
    logic [31:0] exp_a[$];
    errors = 0; checks = 0; running = 1'b0; cur_t = 0;
    rst_n = 1'b0;
    idle_inputs();

    // Sequential fetch with a 3-cycle wait, branch taken/not taken at 0x10, stall+halt at 0x20.
    prog.delete();
    prog.push_back('{w: 0, s: 0, src: 0, imm: 32'h0,         hlt: 0, word: 32'h0000_0013});
    prog.push_back('{w: 3, s: 0, src: 0, imm: 32'h0,         hlt: 0, word: 32'h0040_0093});
    prog.push_back('{w: 0, s: 1, src: 0, imm: 32'h0,         hlt: 0, word: 32'h0080_0113});
    prog.push_back('{w: 0, s: 0, src: 0, imm: 32'h0,         hlt: 0, word: 32'h00C0_0193});
    prog.push_back('{w: 1, s: 0, src: 1, imm: 32'hFFFF_FFF8, hlt: 0, word: 32'hFE00_0CE3});
    prog.push_back('{w: 0, s: 0, src: 0, imm: 32'h0,         hlt: 0, word: 32'h0080_0113});
    prog.push_back('{w: 0, s: 0, src: 0, imm: 32'h0,         hlt: 0, word: 32'h00C0_0193});
    prog.push_back('{w: 0, s: 0, src: 0, imm: 32'h0,         hlt: 0, word: 32'h0100_0213});
    prog.push_back('{w: 0, s: 0, src: 1, imm: 32'h0000_000C, hlt: 0, word: 32'h0000_0663});
    prog.push_back('{w: 0, s: 2, src: 0, imm: 32'h0,         hlt: 1, word: 32'h0010_0073});
    build(6);
    run(n_cyc);
    exp_a = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h8, 32'hC, 32'h10, 32'h14, 32'h20};
    chk_fetches("seq_branch", exp_a);
    chk("seq_final_pc", pc, 32'h20);
    chk("seq_final_halted", {31'h0, halted}, 32'h1);
    chk("seq_final_req", {31'h0, bus.imem_req}, 32'h0);
`ifdef PC_FETCH_INSTRET_EN
    chk("seq_instret", instret, 32'd9);
`endif

    // Misaligned branch target from 0x40.
    prog.delete();
    prog.push_back('{w: 0, s: 0, src: 0, imm: 32'h0,         hlt: 0, word: 32'h1111_0001});
    prog.push_back('{w: 2, s: 0, src: 1, imm: 32'h0000_003C, hlt: 0, word: 32'h2222_0002});
    prog.push_back('{w: 0, s: 1, src: 1, imm: 32'h0000_0002, hlt: 0, word: 32'h3333_0003});
    build(5);
    run(n_cyc);
    exp_a = '{32'h0, 32'h4, 32'h40};
    chk_fetches("misalign", exp_a);
    chk("mis_final_pc", pc, 32'h40);
    chk("mis_final_flag", {31'h0, misaligned}, 32'h1);
    chk("mis_final_halted", {31'h0, halted}, 32'h1);
`ifdef PC_FETCH_INSTRET_EN
    chk("mis_instret", instret, 32'd3);
`endif

    // Reset asserted while the fetch of 0x8 is waiting for ack.
    prog.delete();
    prog.push_back('{w: 0, s: 0, src: 0, imm: 32'h0, hlt: 0, word: 32'h4444_0004});
    prog.push_back('{w: 0, s: 0, src: 0, imm: 32'h0, hlt: 0, word: 32'h5555_0005});
    prog.push_back('{w: 6, s: 0, src: 0, imm: 32'h0, hlt: 1, word: 32'h6666_0006});
    build(0);
    run(7);
    cur_t = 7;
    drive(7);
    chk("midfetch_req", {31'h0, bus.imem_req}, 32'h1);
    chk("midfetch_addr", bus.imem_addr, 32'h8);
    rst_n = 1'b0;
    #1;
    chk("rst_req_drop", {31'h0, bus.imem_req}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);

    // Wrap-around: branch to 0xFFFF_FFFC, sequential update wraps to 0; late ack in BOOT ignored.
    prog.delete();
    prog.push_back('{w: 0, s: 0, src: 1, imm: 32'hFFFF_FFFC, hlt: 0, word: 32'h7777_0007});
    prog.push_back('{w: 1, s: 1, src: 0, imm: 32'h0,         hlt: 0, word: 32'h8888_0008});
    prog.push_back('{w: 0, s: 0, src: 0, imm: 32'h0,         hlt: 1, word: 32'h9999_0009});
    build(4);
    run(n_cyc);
    exp_a = '{32'h0, 32'hFFFF_FFFC, 32'h0};
    chk_fetches("wrap", exp_a);
    chk("wrap_final_instr", instr, 32'h9999_0009);
    chk("wrap_final_mis", {31'h0, misaligned}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage directly upstream of the decode/control unit.
- Holds the PC and fetches one instruction at a time from instruction memory over a req/ack handshake.
- Presents each instruction to decode for exactly one issue cycle, then updates the PC from the decode results:
  - branch select `pc_src`
  - immediate `imm_ext`
  - `halt`
- Retire model: one instruction in flight at a time, no pipelining.

Parameters:
- XLEN, 32, width of PC, instruction and immediate.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  XLEN  fetch address; equals pc while imem_req=1.
- imem_rdata  in  XLEN  instruction word; sampled on the cycle imem_ack=1.
- imem_ack  in  1  memory response strobe.
- instr  out  XLEN  registered instruction; decode reads op, funct3 and funct7_5 from it.
- instr_valid  out  1  issue cycle; instr and pc are valid and decode outputs are consumed this cycle.
- pc  out  XLEN  address of the current instruction.
- pc_src  in  1  from decode: 1 selects the branch target.
- imm_ext  in  XLEN  from decode: sign-extended branch offset.
- halt  in  1  from decode: stop fetching.
- stall  in  1  hold the issue cycle (e.g. data memory busy).
- halted  out  1  sticky, core stopped.
- misaligned  out  1  sticky, halt was caused by a non-word-aligned next PC.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=BOOT, pc=RESET_PC, instr=0.
  - instr_valid=0, imem_req=0, halted=0, misaligned=0.
- State machine; all outputs are Moore-decoded from registered state:
  - BOOT:
    - One cycle after reset release; outputs idle.
    - Next state FETCH.
  - FETCH:
    - imem_req=1, imem_addr=pc.
    - Request and address are held stable until imem_ack=1.
    - On ack: instr<=imem_rdata, then go to ISSUE.
    - Ack may arrive in the first FETCH cycle (combinational memory).
  - ISSUE:
    - instr_valid=1; pc and instr are stable.
    - If stall=1: stay in ISSUE; all registers hold; decode inputs are ignored.
    - If stall=0 and halt=1: go to HALTED, halted<=1, pc unchanged.
    - Otherwise compute next_pc = pc_src ? pc+imm_ext : pc+4.
      - Addition is modulo 2^XLEN; wrap-around is legal.
    - If next_pc[1:0]!=0: go to HALTED, misaligned<=1, halted<=1, pc unchanged.
    - Otherwise pc<=next_pc and go to FETCH.
  - HALTED:
    - imem_req=0, instr_valid=0.
    - Exited only by reset.
- Priority in ISSUE: stall > halt > misalign > normal update.
- imem_ack outside FETCH is ignored; no capture, no state change.
- Latency:
  - Minimum 2 cycles per instruction (1 FETCH + 1 ISSUE).
  - Each imem wait cycle and each stall cycle adds one cycle.
- Reset mid-fetch: request drops immediately (asynchronous). A late ack after reset release is ignored because state is BOOT.
- instr_valid is never asserted in consecutive cycles for different instructions.

Optional Feature:
- Macro: PC_FETCH_INSTRET_EN.
- Defined:
  - Adds output instret [XLEN-1:0], reset to 0.
  - Increments by 1 on each ISSUE cycle with stall=0 and halt=0, including cycles that trigger misaligned.
  - Wraps at 2^XLEN.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset and sequential fetch, zero-wait memory:
  - Stimulus: release rst_n with RESET_PC=0.
  - Required response: BOOT for 1 cycle, then imem_addr sequence 0,4,8,C.
  - Required response: instr_valid every 2nd cycle, pc matching each address.
- Wait states:
  - Stimulus: imem_ack delayed 3 cycles.
  - Required response: imem_req and imem_addr held constant for 4 cycles.
  - Required response: instr equals imem_rdata sampled on the ack cycle.
- Branch taken and not taken:
  - Stimulus: at pc=0x10, pc_src=1 with imm_ext=-8.
  - Required response: next fetch address is 0x08.
  - Stimulus: at pc=0x10, pc_src=0.
  - Required response: next fetch address is 0x14.
- Stall then halt:
  - Stimulus: in ISSUE at pc=0x20, stall=1 for 2 cycles with halt=1.
  - Required response: instr_valid stays 1 for 3 cycles, pc stays 0x20.
  - Required response: halted=1 afterwards and imem_req stays 0 forever.
- Misaligned target:
  - Stimulus: at pc=0x40, pc_src=1 with imm_ext=2.
  - Required response: misaligned=1, halted=1, pc remains 0x40, no further request.
- Reset mid-fetch and wrap:
  - Stimulus: assert rst_n=0 during a pending request.
  - Required response: imem_req drops the same cycle and pc returns to RESET_PC.
  - Stimulus: pc=0xFFFF_FFFC with a sequential update.
  - Required response: next fetch address is 0x0000_0000.
  - With PC_FETCH_INSTRET_EN defined: instret counts 4 after four retired instructions.
